// File: rtl/l7_loop_seq.sv
// l7_loop_seq: loop-nest sequencer for the layer-7 convolution datapath.
//
// On an accepted start the pass mode u is latched and the tap (k), input-channel (L),
// column (j) and row (R) counters are walked, innermost first, one step per cycle while
// step_en is high. Each issued step raises mac_en, plus acc_clr on the first MAC of an
// output pixel and the per-counter wrap pulses. The last MAC of each pixel (L_zero) is
// delayed PIPE cycles to produce wr_en.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start             one-cycle pass request, sampled only in IDLE
//   u                 pass mode, latched on accepted start (3 or 4 -> 3 taps, else 1)
//   step_en           datapath ready; low freezes the nest in RUN
//   k, L, j, R        current tap / input channel / column / row
//   k_zero .. R_zero  wrap pulses on an issued step
//   mac_en            MAC issue strobe
//   acc_clr           clear accumulator alongside this MAC
//   wr_en             write completed output pixel
//   busy              high from LOAD through DONE
//   done              one-cycle completion pulse
//
// Optional feature (macro L7_SEQ_PERF_EN): adds 16-bit saturating perf_cycles
// (RUN/DRAIN cycles) and perf_stalls (RUN cycles with step_en low).

module l7_loop_seq #(
    parameter int unsigned J_MAX = 13,
    parameter int unsigned L_MAX = 63,
    parameter int unsigned R_MAX = 5,
    parameter int unsigned PIPE  = 2,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    u,
    input  logic          step_en,
    output logic [1:0]    k,
    output logic [2:0]    R,
    output logic [CW-1:0] L,
    output logic [CW-1:0] j,
    output logic          k_zero,
    output logic          L_zero,
    output logic          j_zero,
    output logic          R_zero,
    output logic          mac_en,
    output logic          acc_clr,
    output logic          wr_en,
    output logic          busy,
`ifdef L7_SEQ_PERF_EN
    output logic [15:0]   perf_cycles,
    output logic [15:0]   perf_stalls,
`endif
    output logic          done
);

    localparam int unsigned DW = (PIPE > 1) ? $clog2(PIPE) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      u_q, u_d;
    logic [1:0]      k_q, k_d;
    logic [CW-1:0]   l_q, l_d;
    logic [CW-1:0]   j_q, j_d;
    logic [2:0]      r_q, r_d;
    logic [PIPE-1:0] pipe_q, pipe_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [1:0]      k_last;

    assign k_last = (u_q == 3'd3 || u_q == 3'd4) ? 2'd2 : 2'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            u_q     <= '0;
            k_q     <= '0;
            l_q     <= '0;
            j_q     <= '0;
            r_q     <= '0;
            pipe_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            k_q     <= k_d;
            l_q     <= l_d;
            j_q     <= j_d;
            r_q     <= r_d;
            pipe_q  <= pipe_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        k_d     = k_q;
        l_d     = l_q;
        j_d     = j_q;
        r_d     = r_q;
        drain_d = drain_q;
        mac_en  = 1'b0;
        k_zero  = 1'b0;
        L_zero  = 1'b0;
        j_zero  = 1'b0;
        R_zero  = 1'b0;
        acc_clr = 1'b0;
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    u_d     = u;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                k_d     = '0;
                l_d     = '0;
                j_d     = '0;
                r_d     = '0;
                state_d = StRun;
            end
            StRun: begin
                if (step_en) begin
                    mac_en  = 1'b1;
                    k_zero  = (k_q == k_last);
                    L_zero  = k_zero && (l_q == CW'(L_MAX));
                    j_zero  = L_zero && (j_q == CW'(J_MAX));
                    R_zero  = j_zero && (r_q == 3'(R_MAX));
                    acc_clr = (k_q == 2'd0) && (l_q == '0);
                    if (R_zero) begin
                        // Final step: counters keep their last values through DRAIN.
                        drain_d = '0;
                        state_d = StDrain;
                    end else begin
                        k_d = k_zero ? 2'd0 : k_q + 2'd1;
                        if (k_zero) l_d = L_zero ? '0 : l_q + 1'b1;
                        if (L_zero) j_d = j_zero ? '0 : j_q + 1'b1;
                        if (j_zero) r_d = r_q + 3'd1;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DW'(PIPE - 1)) state_d = StDone;
                else                          drain_d = drain_q + 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Shifts every cycle, independent of step_en.
        pipe_d = PIPE'({pipe_q, L_zero});
    end

    assign k     = k_q;
    assign L     = l_q;
    assign j     = j_q;
    assign R     = r_q;
    assign wr_en = pipe_q[PIPE-1];

`ifdef L7_SEQ_PERF_EN
    logic [15:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == StLoad) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if ((state_q == StRun || state_q == StDrain) && perf_cycles_q != 16'hFFFF) begin
                perf_cycles_q <= perf_cycles_q + 16'd1;
            end
            if (state_q == StRun && !step_en && perf_stalls_q != 16'hFFFF) begin
                perf_stalls_q <= perf_stalls_q + 16'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_l7_loop_seq.sv
// Directed bench for l7_loop_seq with J_MAX = L_MAX = R_MAX = 1, PIPE = 2.
// Each pass records per-cycle strobes into bit masks (bit c = cycle c after start)
// and compares them against hand-computed masks.

module tb_l7_loop_seq;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    u = 3'd0;
    logic          step_en = 1'b0;
    logic [1:0]    k;
    logic [2:0]    R;
    logic [CW-1:0] L, j;
    logic          k_zero, L_zero, j_zero, R_zero;
    logic          mac_en, acc_clr, wr_en, busy, done;
`ifdef L7_SEQ_PERF_EN
    logic [15:0]   perf_cycles, perf_stalls;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] m_mac, m_wr, m_clr, m_done, m_kz, m_lz, m_rz, m_busy;
    logic [1:0]    k_log [64];
    logic [CW-1:0] l_log [64];

    l7_loop_seq #(
        .J_MAX(1), .L_MAX(1), .R_MAX(1), .PIPE(2), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .u          (u),
        .step_en    (step_en),
        .k          (k),
        .R          (R),
        .L          (L),
        .j          (j),
        .k_zero     (k_zero),
        .L_zero     (L_zero),
        .j_zero     (j_zero),
        .R_zero     (R_zero),
        .mac_en     (mac_en),
        .acc_clr    (acc_clr),
        .wr_en      (wr_en),
        .busy       (busy),
`ifdef L7_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({mac_en, acc_clr, wr_en, busy, done, k_zero, L_zero, j_zero, R_zero,
                    k, R, L, j});
    endfunction

    // Called at posedge+1; cycle 0 is the cycle start is driven. Returns at posedge+1.
    task automatic run(input logic [2:0] uv, input logic [63:0] stall, input int restart,
                       input int rst_cyc, input int ncyc);
        m_mac = '0; m_wr = '0; m_clr = '0; m_done = '0;
        m_kz = '0; m_lz = '0; m_rz = '0; m_busy = '0;
        for (int c = 0; c < ncyc; c++) begin
            start   = (c == 0) || (c == restart);
            u       = (c == 0) ? uv : 3'd7;  // later u changes must not matter
            step_en = !stall[c];
            if (c == rst_cyc + 1) rst = 1'b1;
            if (c == rst_cyc) begin
                rst = 1'b0;
                #1;
                chk("async_rst_outs", all_outs(), 64'd0);
            end
            @(negedge clk);
            m_mac[c]  = mac_en;
            m_wr[c]   = wr_en;
            m_clr[c]  = acc_clr;
            m_done[c] = done;
            m_kz[c]   = k_zero;
            m_lz[c]   = L_zero;
            m_rz[c]   = R_zero;
            m_busy[c] = busy;
            k_log[c]  = k;
            l_log[c]  = L;
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        step_en = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_outs", all_outs(), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // u=0, no stalls
        run(3'd0, 64'd0, -1, -1, 15);
        chk("t1_mac", m_mac, 64'h3FC);
        chk("t1_wr", m_wr, 64'hAA0);
        chk("t1_done", m_done, 64'h1000);
        chk("t1_clr", m_clr, 64'h154);
        chk("t1_busy", m_busy, 64'h1FFE);

        // u=3, three taps
        run(3'd3, 64'd0, -1, -1, 31);
        chk("t2_mac", m_mac, 64'h3FFFFFC);
        chk("t2_kzero", m_kz, 64'h2492490);
        chk("t2_rzero", m_rz, 64'h2000000);
        chk("t2_done", m_done, 64'h10000000);
        chk("t2_k2", 64'(k_log[2]), 64'd0);
        chk("t2_k3", 64'(k_log[3]), 64'd1);
        chk("t2_k4", 64'(k_log[4]), 64'd2);
        chk("t2_k5", 64'(k_log[5]), 64'd0);
        chk("t2_l5", 64'(l_log[5]), 64'd1);

        // u=0, step_en low on cycles 3 and 4
        run(3'd0, 64'h18, -1, -1, 17);
        chk("t3_mac", m_mac, 64'hFE4);
        chk("t3_lzero", m_lz, 64'hAA0);
        chk("t3_wr", m_wr, 64'h2A80);
        chk("t3_done", m_done, 64'h4000);
        chk("t3_l3", 64'(l_log[3]), 64'd1);
        chk("t3_l4", 64'(l_log[4]), 64'd1);
        chk("t3_k4", 64'(k_log[4]), 64'd0);
`ifdef L7_SEQ_PERF_EN
        chk("t3_perf_stalls", 64'(perf_stalls), 64'd2);
        chk("t3_perf_cycles", 64'(perf_cycles), 64'd12);
`endif

        // start re-pulsed on cycle 6 is ignored
        run(3'd0, 64'd0, 6, -1, 20);
        chk("t4_mac", m_mac, 64'h3FC);
        chk("t4_done", m_done, 64'h1000);

        // reset on cycle 5, new start on cycle 8
        run(3'd0, 64'd0, 8, 5, 23);
        chk("t5_mac", m_mac, 64'h3FC1C);
        chk("t5_done", m_done, 64'h100000);
        chk("t5_busy", m_busy, 64'h1FFE1E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
